// File: rtl/lane_pipe_pkg.sv
// Shared defaults and helpers for the per-lane elastic pipeline.
// The occupancy counter width is derived from the stage count and is never set directly.
package lane_pipe_pkg;

  localparam int DEFAULT_LANES = 4;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 3;

  // Bits needed to count from 0 up to and including depth.
  function automatic int calcCntw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lane_pipe_stage.sv
// One valid/data register of a lane. It loads whenever it is empty or its
// downstream neighbour can take its word, so bubbles collapse toward the output.
module lane_pipe_stage
  import lane_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             down_ready_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  assign ready_o = !valid_q || down_ready_i;

  // Data follows valid unconditionally on a load, so an empty stage keeps the last value it took.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready_o) begin
      valid_d = up_valid_i;
      data_d  = up_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/lane_pipe_gen.sv
// LANES independent elastic pipelines, each DEPTH stages deep, with a registered
// per-lane occupancy count. Lanes share only the clock and reset.
module lane_pipe_gen
  import lane_pipe_pkg::*;
#(
  parameter int   LANES = DEFAULT_LANES,
  parameter int   WIDTH = DEFAULT_WIDTH,
  parameter int   DEPTH = DEFAULT_DEPTH,
  localparam int  CNTW  = calcCntw(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       in_ready,
  output logic [LANES-1:0]       out_valid,
  output logic [LANES*WIDTH-1:0] out_data,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*CNTW-1:0]  occupancy
);

  for (genvar i = 0; i < LANES; i++) begin : lane
    logic            acceptLane;
    logic            emitLane;
    logic [CNTW-1:0] occ_q, occ_d;

    for (genvar j = 0; j < DEPTH; j++) begin : stage
      logic             upValid;
      logic [WIDTH-1:0] upData;
      logic             downReady;
      logic             ready;
      logic             valid;
      logic [WIDTH-1:0] data;

      if (j == 0) begin : gUp
        assign upValid = in_valid[i];
        assign upData  = in_data[i*WIDTH +: WIDTH];
      end else begin : gUp
        assign upValid = stage[j-1].valid;
        assign upData  = stage[j-1].data;
      end

      // Each stage sees its own downstream neighbour's ready, which keeps the chain acyclic per signal.
      if (j == DEPTH - 1) begin : gDown
        assign downReady = out_ready[i];
      end else begin : gDown
        assign downReady = stage[j+1].ready;
      end

      lane_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk         (clk),
        .rst_n       (rst_n),
        .up_valid_i  (upValid),
        .up_data_i   (upData),
        .down_ready_i(downReady),
        .ready_o     (ready),
        .valid_o     (valid),
        .data_o      (data)
      );
    end

    assign in_ready[i]                  = stage[0].ready;
    assign out_valid[i]                 = stage[DEPTH-1].valid;
    assign out_data[i*WIDTH +: WIDTH]   = stage[DEPTH-1].data;

    assign acceptLane = in_valid[i] && stage[0].ready;
    assign emitLane   = stage[DEPTH-1].valid && out_ready[i];

    always_comb begin
      occ_d = occ_q;
      if (acceptLane && !emitLane) begin
        occ_d = occ_q + CNTW'(1);
      end else if (!acceptLane && emitLane) begin
        occ_d = occ_q - CNTW'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occ_q <= '0;
      end else begin
        occ_q <= occ_d;
      end
    end

    assign occupancy[i*CNTW +: CNTW] = occ_q;
  end

endmodule

// File: tb/tb_lane_pipe_gen.sv
// Self-checking bench for lane_pipe_gen: directed scenarios plus random traffic,
// compared every cycle against a per-lane queue model of words and their positions.
module tb_lane_pipe_gen;

  localparam int L  = 4;
  localparam int W  = 4;
  localparam int D  = 3;
  localparam int CW = $clog2(D + 1);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [L-1:0]   in_valid = '0;
  logic [L*W-1:0] in_data = '0;
  logic [L-1:0]   in_ready;
  logic [L-1:0]   out_valid;
  logic [L*W-1:0] out_data;
  logic [L-1:0]   out_ready = '0;
  logic [L*CW-1:0] occupancy;

  always #5 clk = ~clk;

  lane_pipe_gen #(.LANES(L), .WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  // A lane is a queue of words, oldest first, each tagged with the stage it sits in.
  typedef struct {
    int         pos;
    logic [W-1:0] data;
  } entry_t;

  entry_t lq [L][$];
  int checks = 0;
  int errors = 0;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The entry stage is blocked only when the lane is full and the consumer stalls.
  function automatic logic modelReady(input int i);
    return (lq[i].size() < D) || out_ready[i];
  endfunction

  function automatic logic modelValid(input int i);
    return (lq[i].size() > 0) && (lq[i][0].pos == D - 1);
  endfunction

  function automatic logic [L*W-1:0] lanesWord(input int lane, input logic [W-1:0] v);
    logic [L*W-1:0] r;
    r = '0;
    r[lane*W +: W] = v;
    return r;
  endfunction

  task automatic checkOutput();
    for (int i = 0; i < L; i++) begin
      checkValue($sformatf("in_ready[%0d]", i), 32'(in_ready[i]), 32'(modelReady(i)));
      checkValue($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(modelValid(i)));
      checkValue($sformatf("occupancy[%0d]", i), 32'(occupancy[i*CW +: CW]), 32'(lq[i].size()));
      if (modelValid(i)) begin
        checkValue($sformatf("out_data[%0d]", i), 32'(out_data[i*W +: W]), 32'(lq[i][0].data));
      end
    end
  endtask

  // A word moves one stage forward unless every stage from it to the output is occupied and the consumer stalls.
  task automatic modelEdge();
    for (int i = 0; i < L; i++) begin
      logic   acc;
      logic   em;
      entry_t e;
      entry_t nq[$];
      nq.delete();
      acc = in_valid[i] && modelReady(i);
      em  = modelValid(i) && out_ready[i];
      for (int k = 0; k < lq[i].size(); k++) begin
        if (k == 0 && em) continue;
        e = lq[i][k];
        if (out_ready[i] || (k != D - 1 - e.pos)) e.pos++;
        nq.push_back(e);
      end
      if (acc) begin
        e.pos  = 0;
        e.data = in_data[i*W +: W];
        nq.push_back(e);
      end
      lq[i] = nq;
    end
  endtask

  task automatic applyStimulus(input logic [L-1:0] iv, input logic [L*W-1:0] id, input logic [L-1:0] ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus('0, '0, '1);
  endtask

  task automatic resetCheck(input string tag);
    for (int i = 0; i < L; i++) begin
      checkValue($sformatf("%s out_valid[%0d]", tag, i), 32'(out_valid[i]), 32'd0);
      checkValue($sformatf("%s in_ready[%0d]", tag, i), 32'(in_ready[i]), 32'd1);
      checkValue($sformatf("%s occupancy[%0d]", tag, i), 32'(occupancy[i*CW +: CW]), 32'd0);
      checkValue($sformatf("%s out_data[%0d]", tag, i), 32'(out_data[i*W +: W]), 32'd0);
    end
  endtask

  // Asserts reset between edges, checks the immediate effect, then releases between edges.
  task automatic midReset(input string tag);
    rst_n    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    #1;
    resetCheck(tag);
    for (int i = 0; i < L; i++) lq[i].delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < L; i++) lq[i].delete();

    // Reset state and release with nothing offered.
    #12;
    resetCheck("in_reset");
    rst_n = 1'b1;
    #1;
    resetCheck("after_release");
    @(posedge clk);
    #1;
    resetCheck("first_edge");

    // Lane 0 streams 1..4 with all consumers ready.
    for (int v = 1; v <= 3; v++) applyStimulus(4'b0001, lanesWord(0, 4'(v)), '1);
    checkValue("stream_first_valid", 32'(out_valid[0]), 32'd1);
    checkValue("stream_first_data", 32'(out_data[3:0]), 32'd1);
    checkValue("stream_peak_occ", 32'(occupancy[CW-1:0]), 32'd3);
    applyStimulus(4'b0001, lanesWord(0, 4'd4), '1);
    checkValue("stream_second_data", 32'(out_data[3:0]), 32'd2);
    idle(D + 2);

    // Lane 2 stalled: fills with A,B,C and refuses D until the consumer resumes.
    applyStimulus(4'b0100, lanesWord(2, 4'hA), 4'b1011);
    applyStimulus(4'b0100, lanesWord(2, 4'hB), 4'b1011);
    applyStimulus(4'b0100, lanesWord(2, 4'hC), 4'b1011);
    in_data = lanesWord(2, 4'hD);
    #1;
    checkValue("stall_in_ready", 32'(in_ready[2]), 32'd0);
    checkValue("stall_occ", 32'(occupancy[2*CW +: CW]), 32'd3);
    checkValue("stall_head", 32'(out_data[2*W +: W]), 32'hA);
    applyStimulus(4'b0100, lanesWord(2, 4'hD), 4'b1011);
    checkValue("stall_frozen_head", 32'(out_data[2*W +: W]), 32'hA);
    applyStimulus(4'b0100, lanesWord(2, 4'hD), '1);
    idle(D + 2);

    // Lane 1 full, then accept and emit in the same cycle.
    for (int v = 1; v <= 3; v++) applyStimulus(4'b0010, lanesWord(1, 4'(v)), 4'b1101);
    in_valid  = 4'b0010;
    in_data   = lanesWord(1, 4'd4);
    out_ready = '1;
    #1;
    checkValue("full_pass_in_ready", 32'(in_ready[1]), 32'd1);
    applyStimulus(4'b0010, lanesWord(1, 4'd4), '1);
    checkValue("full_pass_occ", 32'(occupancy[1*CW +: CW]), 32'd3);
    checkValue("full_pass_head", 32'(out_data[1*W +: W]), 32'd2);
    idle(D + 2);

    // Lane 3 stalled full while lane 0 streams 5,6,7.
    applyStimulus(4'b1000, lanesWord(3, 4'd9), 4'b0111);
    applyStimulus(4'b1000, lanesWord(3, 4'd8), 4'b0111);
    applyStimulus(4'b1000, lanesWord(3, 4'd7), 4'b0111);
    for (int v = 5; v <= 7; v++) applyStimulus(4'b1001, lanesWord(0, 4'(v)) | lanesWord(3, 4'hF), 4'b0111);
    checkValue("indep_lane0_data", 32'(out_data[3:0]), 32'd5);
    checkValue("indep_lane3_data", 32'(out_data[3*W +: W]), 32'd9);
    checkValue("indep_lane3_occ", 32'(occupancy[3*CW +: CW]), 32'd3);
    idle(D + 2);

    // Reset mid-stream with two words in lane 0; they must never appear.
    applyStimulus(4'b0001, lanesWord(0, 4'd1), 4'b1110);
    applyStimulus(4'b0001, lanesWord(0, 4'd2), 4'b1110);
    midReset("mid_reset");
    idle(D + 2);

    // Random traffic with one asynchronous reset part way through.
    for (int n = 0; n < 300; n++) begin
      if (n == 150) midReset("rand_reset");
      applyStimulus(L'($urandom), (L*W)'($urandom), L'($urandom));
    end
    idle(D + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
